// File: rtl/imem_uart_loader_if.sv
// imem_uart_loader_if: instruction memory write port driven by the boot loader
interface imem_uart_loader_if #(parameter int WIDTH = 32);
  logic             insMemEn;
  logic [WIDTH-1:0] insMemData;
  logic [WIDTH-1:0] insMemAddr;
  modport master (output insMemEn, insMemData, insMemAddr);
  modport slave  (input  insMemEn, insMemData, insMemAddr);
endinterface

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader writing a length-prefixed image into instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing 32-bit wrap-around sum of the data words.
module imem_uart_loader #(
  parameter int WIDTH        = 32,
  parameter int IMEM_DEPTH   = 512,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  imem_uart_loader_if.master imem,
  output logic cpuReset,
  output logic loadDone,
  output logic loadError
);
  localparam int IW = $clog2(IMEM_DEPTH + 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
  localparam logic [2:0] LEN = 3'd0, DATA = 3'd1, DONE = 3'd3, ERROR = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] CSUM = 3'd2;
  localparam logic [2:0] FIN  = CSUM;
`else
  localparam logic [2:0] FIN  = DONE;
`endif
  logic          rx_m, rx_s, rx_d;
  logic [1:0]    rx_st;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    rx_sh;
  logic          rx_valid, rx_ferr;
  logic          clk_hit, half_hit;
  logic [2:0]    st;
  logic [1:0]    byte_cnt;
  logic [23:0]   sh;
  logic [31:0]   word;
  logic [IW-1:0] idx, n;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   sum;
`endif
  assign clk_hit  = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign half_hit = clk_cnt == CW'(CLKS_PER_BIT / 2 - 1);
  assign word     = {rx_sh, sh};
  assign cpuReset  = st != DONE;
  assign loadDone  = st == DONE;
  assign loadError = st == ERROR;
  // rx_d is one synchronized sample behind rx_s for start-edge detection
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_d     <= 1'b1;
      rx_st    <= RX_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_m     <= rx;
      rx_s     <= rx_m;
      rx_d     <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      clk_cnt  <= clk_cnt + CW'(1);
      case (rx_st)
        RX_IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (rx_d && !rx_s) rx_st <= RX_START;
        end
        RX_START: if (half_hit) begin
          clk_cnt <= '0;
          rx_st   <= rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (clk_hit) begin
          clk_cnt <= '0;
          rx_sh   <= {rx_s, rx_sh[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) rx_st <= RX_STOP;
        end
        default: if (clk_hit) begin
          rx_valid <= rx_s;
          rx_ferr  <= !rx_s;
          rx_st    <= RX_IDLE;
        end
      endcase
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      st              <= LEN;
      byte_cnt        <= '0;
      sh              <= '0;
      idx             <= '0;
      n               <= '0;
      imem.insMemEn   <= 1'b0;
      imem.insMemData <= '0;
      imem.insMemAddr <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum             <= '0;
`endif
    end else begin
      imem.insMemEn <= 1'b0;
      if (rx_ferr && st != DONE) st <= ERROR;
      else if (rx_valid && st < DONE) begin
        byte_cnt <= byte_cnt + 2'd1;
        sh       <= word[31:8];
        if (byte_cnt == 2'd3) begin
          if (st == LEN) begin
            idx <= '0;
            n   <= IW'(word);
            st  <= word == 32'd0 ? FIN : word > 32'(IMEM_DEPTH) ? ERROR : DATA;
          end else if (st == DATA) begin
            imem.insMemEn   <= 1'b1;
            imem.insMemData <= WIDTH'(word);
            imem.insMemAddr <= WIDTH'(idx);
            idx             <= idx + IW'(1);
`ifdef LOADER_CHECKSUM_EN
            sum             <= sum + word;
          end else begin
            st <= word == sum ? DONE : ERROR;
`endif
          end
        end
      // leave DATA only after the final strobe cycle so the write lands before cpuReset drops
      end else if (st == DATA && imem.insMemEn && idx == n) st <= FIN;
    end
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: directed UART frames against the loader with hand-computed expectations
module tb_imem_uart_loader;
  localparam int CPB = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx = 1'b1;
  logic cpuReset, loadDone, loadError;
  int checks = 0, errors = 0;
  int cyc = 0, npulse = 0, pulse_cyc = 0, done_cyc = 0, wide = 0, base = 0;
  logic [31:0] paddr [64];
  logic [31:0] pdata [64];
  logic en_d = 1'b0, done_d = 1'b0;

  imem_uart_loader_if #(.WIDTH(32)) imem ();
  imem_uart_loader #(.WIDTH(32), .IMEM_DEPTH(512), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .rx(rx), .imem(imem),
    .cpuReset(cpuReset), .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    cyc++;
    if (imem.insMemEn) begin
      if (npulse < 64) begin
        paddr[npulse] = imem.insMemAddr;
        pdata[npulse] = imem.insMemData;
      end
      npulse++;
      pulse_cyc = cyc;
      if (en_d) wide++;
    end
    if (loadDone && !done_d) done_cyc = cyc;
    en_d = imem.insMemEn;
    done_d = loadDone;
  end

  initial begin
    repeat (200000) @(negedge clock);
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic send_csum(input logic [31:0] w);
`ifdef LOADER_CHECKSUM_EN
    send_word(w);
`else
    if (w == 32'hffff_ffff) send_word(w);
`endif
  endtask

  task automatic do_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_en"}, {31'd0, imem.insMemEn}, 32'd0);
    check({tag, "_data"}, imem.insMemData, 32'd0);
    check({tag, "_addr"}, imem.insMemAddr, 32'd0);
    check({tag, "_cpurst"}, {31'd0, cpuReset}, 32'd1);
    check({tag, "_done"}, {31'd0, loadDone}, 32'd0);
    check({tag, "_err"}, {31'd0, loadError}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    base = npulse;
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_csum(32'h0010_00a6);
    repeat (10) @(negedge clock);
    check("s1_pulses", 32'(npulse - base), 32'd2);
    check("s1_a0", paddr[base], 32'd0);
    check("s1_d0", pdata[base], 32'h0000_0013);
    check("s1_a1", paddr[base + 1], 32'd1);
    check("s1_d1", pdata[base + 1], 32'h0010_0093);
    check("s1_hold", imem.insMemData, 32'h0010_0093);
    check("s1_wide", 32'(wide), 32'd0);
    check("s1_done", {31'd0, loadDone}, 32'd1);
    check("s1_cpurst", {31'd0, cpuReset}, 32'd0);
    check("s1_err", {31'd0, loadError}, 32'd0);
`ifndef LOADER_CHECKSUM_EN
    check("s1_done_cyc", 32'(done_cyc), 32'(pulse_cyc + 1));
`endif

    do_reset();
    base = npulse;
    send_word(32'd0);
    send_csum(32'd0);
    check("s2_done", {31'd0, loadDone}, 32'd1);
    send_word(32'd1);
    send_word(32'hdead_beef);
    repeat (10) @(negedge clock);
    check("s2_pulses", 32'(npulse - base), 32'd0);
    check("s2_still_done", {31'd0, loadDone}, 32'd1);
    check("s2_err", {31'd0, loadError}, 32'd0);

    do_reset();
    base = npulse;
    send_word(32'd513);
    send_word(32'h1234_5678);
    repeat (10) @(negedge clock);
    check("s3_err", {31'd0, loadError}, 32'd1);
    check("s3_cpurst", {31'd0, cpuReset}, 32'd1);
    check("s3_pulses", 32'(npulse - base), 32'd0);

    do_reset();
    send_word(32'd512);
    repeat (10) @(negedge clock);
    check("len512_err", {31'd0, loadError}, 32'd0);
    check("len512_cpurst", {31'd0, cpuReset}, 32'd1);

    do_reset();
    base = npulse;
    rx = 1'b0;
    repeat (4) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    send_word(32'd1);
    send_word(32'hcafe_f00d);
    send_csum(32'hcafe_f00d);
    repeat (10) @(negedge clock);
    check("s4_pulses", 32'(npulse - base), 32'd1);
    check("s4_a0", paddr[base], 32'd0);
    check("s4_d0", pdata[base], 32'hcafe_f00d);
    check("s4_done", {31'd0, loadDone}, 32'd1);

    do_reset();
    base = npulse;
    send_word(32'd1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    repeat (10) @(negedge clock);
    check("s4f_err", {31'd0, loadError}, 32'd1);
    check("s4f_pulses", 32'(npulse - base), 32'd0);
    check("s4f_cpurst", {31'd0, cpuReset}, 32'd1);

    do_reset();
    base = npulse;
    send_word(32'd2);
    send_word(32'h0000_0013);
    repeat (5) @(negedge clock);
    check("s5_first", 32'(npulse - base), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_vals("s5_rst");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    base = npulse;
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_csum(32'h0010_00a6);
    repeat (10) @(negedge clock);
    check("s5_pulses", 32'(npulse - base), 32'd2);
    check("s5_a0", paddr[base], 32'd0);
    check("s5_a1", paddr[base + 1], 32'd1);
    check("s5_done", {31'd0, loadDone}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    send_word(32'h0010_00a7);
    repeat (10) @(negedge clock);
    check("cs_bad_err", {31'd0, loadError}, 32'd1);
    check("cs_bad_cpurst", {31'd0, cpuReset}, 32'd1);
    check("cs_bad_done", {31'd0, loadDone}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

Boot-time loader that receives a program image over a UART serial line and writes it word-by-word into the processor's instruction memory through the `insMemEn`/`insMemData`/`insMemAddr` port. It sits directly upstream of the processor core. It holds the core in reset until the image is fully written, then releases it. It also reports completion and error status.

## Interface
Parameters:
- `WIDTH`, 32 — instruction word width; must be 32.
- `IMEM_DEPTH`, 512 — number of instruction memory words; maximum accepted image length.
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit; must be ≥ 4.

Ports. One clock; reset is asynchronous and active-low.
- `clock` in 1 — system clock; all state on rising edge.
- `reset` in 1 — asynchronous, active-low reset.
- `rx` in 1 — UART receive line, 8N1, LSB first, idle high; asynchronous to `clock`.
- `insMemEn` out 1 — one-cycle write strobe to the core's instruction memory.
- `insMemData` out WIDTH — word to write; valid while `insMemEn`=1.
- `insMemAddr` out WIDTH — word index 0..N-1, not a byte address; valid while `insMemEn`=1.
- `cpuReset` out 1 — active-high synchronous reset for the core; 1 until load completes.
- `loadDone` out 1 — sticky; image written successfully.
- `loadError` out 1 — sticky; load aborted.

## Operation
- `rx` passes through a 2-flop synchronizer before any use.
- **UART receiver:**
  - A falling edge on the synchronized `rx` starts a byte.
  - The start bit is re-sampled after `CLKS_PER_BIT/2` cycles. If it reads high, the receiver treats it as a glitch and returns to idle.
  - Each of the 8 data bits is then sampled every `CLKS_PER_BIT` cycles, then the stop bit.
  - The receiver pulses an internal byte-valid for one cycle after the stop-bit sample.
- **Frame format:**
  - 4-byte little-endian length N.
  - N words, each 4 bytes little-endian.
  - With `LOADER_CHECKSUM_EN` only: a 4-byte little-endian checksum follows.
- **FSM states:** LEN, DATA, CSUM (macro only), DONE, ERROR. Reset enters LEN.
  - LEN: shift in 4 bytes. After the 4th byte:
    - N=0 → DONE.
    - N>`IMEM_DEPTH` → ERROR.
    - Otherwise → DATA with the word index cleared.
  - DATA: a 2-bit byte counter assembles each word.
    - After the 4th byte of a word, `insMemData` takes the word, `insMemAddr` takes the index, and `insMemEn` pulses.
    - The index then increments.
    - After word N-1 → CSUM if the macro is defined, otherwise DONE.
  - DONE: `loadDone`=1, `cpuReset`=0. All further `rx` traffic is ignored. Exit only via `reset`.
  - ERROR: `loadError`=1, `cpuReset` stays 1, no further writes. Exit only via `reset`.
- **Framing error:** a stop bit sampled low, in any state other than DONE, discards the byte and enters ERROR.
- **Counters:** the word index is wide enough for `IMEM_DEPTH`. `insMemAddr` is zero-extended to WIDTH.

## Timing
- Reset values: `insMemEn`=0, `insMemData`=0, `insMemAddr`=0, `cpuReset`=1, `loadDone`=0, `loadError`=0. The FSM is in LEN with all counters cleared.
- `insMemEn` rises on the clock edge after the byte-valid of a word's 4th byte and is high for exactly 1 cycle.
- `insMemData`/`insMemAddr` hold their last values between strobes.
- Two strobes are at least 4 UART byte times apart; no back-pressure is needed.
- Last write to DONE:
  - Without the macro: `cpuReset` falls and `loadDone` rises on the edge after the final `insMemEn` cycle. The core's write therefore completes before the core leaves reset.
  - With the macro: DONE is entered one cycle after the checksum's 4th byte-valid.
- Reset mid-frame: asserting `reset` at any time returns all outputs to their reset values, including `cpuReset`=1. Any partial byte, word, or length is discarded, and the next frame starts at LEN. Memory contents already written are not cleared.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - CSUM state is present.
  - A 32-bit checksum accumulates as the wrap-around sum of all N data words (not the length).
  - After the 4-byte checksum: equal → DONE; mismatch → ERROR.
  - For N=0 the checksum is still expected and must be 0.
- `LOADER_CHECKSUM_EN` not defined: no CSUM state, no accumulator; DONE follows the last word.

## Test plan
Bench uses `CLKS_PER_BIT`=16, `IMEM_DEPTH`=512.
- Send bytes 02 00 00 00 13 00 00 00 93 00 10 00 (macro off) → exactly two `insMemEn` pulses: addr 0 data 0x00000013, then addr 1 data 0x00100093. `cpuReset` falls and `loadDone`=1 the cycle after the second pulse. `loadError`=0.
- Send length 00 00 00 00 (macro off) → no `insMemEn` pulse; `loadDone`=1 one cycle after the 4th byte. Extra bytes sent afterwards cause no pulses.
- Send length 01 02 00 00 (N=513) → `loadError`=1, no pulses, `cpuReset` stays 1.
- Send a 4-cycle low glitch on `rx`, then a valid frame with N=1 → glitch ignored, one pulse. Separately, send the 2nd data byte with its stop bit low → ERROR, no pulse for that word.
- Pull `reset` low after the first write of an N=2 frame, release it, then resend the full frame → outputs at reset values during reset; two pulses at addr 0 and 1 after resend.
- Macro on: N=2 frame as in the first scenario plus A6 00 10 00 → `loadDone`=1. Same frame plus A7 00 10 00 → `loadError`=1, `cpuReset`=1.
